// File: rtl/tetris_hex_segment_driver_if.sv
// Signal bundle between a HEX PIO out_port and the seven-segment pin driver.
// There is no valid/ready handshake: seg_in, brightness and blink_en are level inputs sampled every clk, and updated is a one-cycle strobe with no backpressure.
interface tetris_hex_segment_driver_if #(
    parameter int PWM_BITS = 4
);
    logic [6:0]          seg_in;
    logic [PWM_BITS-1:0] brightness;
    logic                blink_en;
    logic [6:0]          hex_out;
    logic                blink_phase;
    logic                updated;

    modport master (
        output seg_in, brightness, blink_en,
        input  hex_out, blink_phase, updated
    );

    modport slave (
        input  seg_in, brightness, blink_en,
        output hex_out, blink_phase, updated
    );
endinterface

// File: rtl/tetris_hex_segment_driver.sv
// Per-digit seven-segment output stage: captures the PIO pattern, then applies brightness PWM, optional blink and pin polarity.
module tetris_hex_segment_driver #(
    parameter int PWM_BITS       = 4,
    parameter int BLINK_HALF     = 25000000,
    parameter bit SEG_ACTIVE_LOW = 1'b1
) (
    input  logic                           clk,
    input  logic                           reset,
    tetris_hex_segment_driver_if.slave     bus
);
    localparam int                  CW         = $clog2(BLINK_HALF);
    localparam logic [CW-1:0]       BLINK_LAST = CW'(BLINK_HALF - 1);
    localparam logic [PWM_BITS-1:0] PWM_MAX    = '1;
    localparam logic [6:0]          DARK       = SEG_ACTIVE_LOW ? 7'h7F : 7'h00;

    // The blink state is the visible blink_phase: ON shows the digit, OFF blanks it.
    typedef enum logic {
        BLINK_OFF = 1'b0,
        BLINK_ON  = 1'b1
    } blink_state_t;

    blink_state_t        blink_state, blink_next;
    logic [CW-1:0]       blink_cnt, blink_cnt_next;
    logic [6:0]          seg_q;
    logic                updated_q;
    logic [PWM_BITS-1:0] pwm_cnt;
    logic [PWM_BITS-1:0] bright_q;
    logic [6:0]          hex_q;
    logic                seg_change;
    logic                pwm_on;
    logic [6:0]          lit;

    assign seg_change = (bus.seg_in != seg_q);

    // A new pattern restarts the blink period in the ON phase so it shows at once.
    always_comb begin
        blink_next     = blink_state;
        blink_cnt_next = blink_cnt;
        if (seg_change || !bus.blink_en) begin
            blink_next     = BLINK_ON;
            blink_cnt_next = '0;
        end else if (blink_cnt == BLINK_LAST) begin
            blink_cnt_next = '0;
            blink_next     = (blink_state == BLINK_ON) ? BLINK_OFF : BLINK_ON;
        end else begin
            blink_cnt_next = blink_cnt + CW'(1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            blink_state <= BLINK_ON;
            blink_cnt   <= '0;
        end else begin
            blink_state <= blink_next;
            blink_cnt   <= blink_cnt_next;
        end
    end

    // All-ones brightness is forced fully on; the compare alone would miss one slot.
    assign pwm_on = (pwm_cnt < bright_q) || (bright_q == PWM_MAX);
    assign lit    = seg_q & {7{(blink_state == BLINK_ON) && pwm_on}};

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            seg_q     <= '0;
            updated_q <= 1'b0;
            pwm_cnt   <= '0;
            bright_q  <= '1;
            hex_q     <= DARK;
        end else begin
            seg_q     <= bus.seg_in;
            updated_q <= seg_change;
            pwm_cnt   <= pwm_cnt + PWM_BITS'(1);
            // Brightness is only taken at the wrap so a PWM period is never cut short.
            if (pwm_cnt == PWM_MAX) begin
                bright_q <= bus.brightness;
            end
            hex_q     <= SEG_ACTIVE_LOW ? ~lit : lit;
        end
    end

    assign bus.hex_out     = hex_q;
    assign bus.blink_phase = (blink_state == BLINK_ON);
    assign bus.updated     = updated_q;
endmodule

// File: tb/tb_tetris_hex_segment_driver.sv
// Bench for tetris_hex_segment_driver: active-low and active-high builds driven with identical stimulus.
module tb_tetris_hex_segment_driver;
    logic clk = 1'b0;
    logic reset;

    always #5 clk = ~clk;

    tetris_hex_segment_driver_if #(.PWM_BITS(2)) if_l ();
    tetris_hex_segment_driver_if #(.PWM_BITS(2)) if_h ();

    tetris_hex_segment_driver #(.PWM_BITS(2), .BLINK_HALF(4), .SEG_ACTIVE_LOW(1'b1)) dut_l (
        .clk   (clk),
        .reset (reset),
        .bus   (if_l)
    );

    tetris_hex_segment_driver #(.PWM_BITS(2), .BLINK_HALF(4), .SEG_ACTIVE_LOW(1'b0)) dut_h (
        .clk   (clk),
        .reset (reset),
        .bus   (if_h)
    );

    typedef struct packed {
        logic [6:0] seg;
        logic [1:0] br;
        logic       bl;
        logic [6:0] hex;
        logic       upd;
        logic       ph;
    } vec_t;

    vec_t       vecs [64];
    int         n_vec = 0;
    logic [8:0] exp_q [$];
    int         checks = 0;
    int         passes = 0;

    task automatic add(input logic [6:0] seg, input logic [1:0] br, input logic bl,
                       input logic [6:0] hex, input logic upd, input logic ph);
        vecs[n_vec] = {seg, br, bl, hex, upd, ph};
        n_vec++;
    endtask

    task automatic drive(input logic [6:0] seg, input logic [1:0] br, input logic bl);
        if_l.seg_in = seg; if_l.brightness = br; if_l.blink_en = bl;
        if_h.seg_in = seg; if_h.brightness = br; if_h.blink_en = bl;
    endtask

    task automatic check(input string name, input logic [6:0] act, input logic [6:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    task automatic check_outputs(input string tag, input logic [6:0] hex, input logic upd, input logic ph);
        check({tag, " hex_l"}, if_l.hex_out, hex);
        check({tag, " hex_h"}, if_h.hex_out, ~hex);
        check({tag, " updated"}, {6'd0, if_l.updated}, {6'd0, upd});
        check({tag, " blink_phase"}, {6'd0, if_l.blink_phase}, {6'd0, ph});
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [8:0] e;
        reset = 1'b1;
        drive(7'h3F, 2'd3, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        check_outputs("in_reset", 7'h7F, 1'b0, 1'b1);

        // Edges 1-4: capture, 2-cycle latency, full brightness.
        add(7'h3F, 3, 0, 7'h7F, 1, 1);
        for (int k = 0; k < 3; k++) add(7'h3F, 3, 0, 7'h40, 0, 1);
        // Edges 5-20: brightness 1 gives 1 lit slot in 4, then brightness 0 goes dark.
        add(7'h7F, 1, 0, 7'h40, 1, 1);
        for (int k = 0; k < 4; k++) add(7'h7F, 1, 0, 7'h00, 0, 1);
        for (int k = 0; k < 3; k++) add(7'h7F, 1, 0, 7'h7F, 0, 1);
        add(7'h7F, 1, 0, 7'h00, 0, 1);
        for (int k = 0; k < 7; k++) add(7'h7F, 0, 0, 7'h7F, 0, 1);
        // Edges 21-34: blink at 4-cycle half period.
        add(7'h06, 3, 1, 7'h7F, 1, 1);
        for (int k = 0; k < 3; k++) add(7'h06, 3, 1, 7'h7F, 0, 1);
        add(7'h06, 3, 1, 7'h79, 0, 0);
        for (int k = 0; k < 3; k++) add(7'h06, 3, 1, 7'h7F, 0, 0);
        add(7'h06, 3, 1, 7'h7F, 0, 1);
        for (int k = 0; k < 3; k++) add(7'h06, 3, 1, 7'h79, 0, 1);
        add(7'h06, 3, 1, 7'h79, 0, 0);
        add(7'h06, 3, 1, 7'h7F, 0, 0);
        // Edges 35-40: pattern change in OFF phase restarts the blink period.
        add(7'h5B, 3, 1, 7'h7F, 1, 1);
        for (int k = 0; k < 3; k++) add(7'h5B, 3, 1, 7'h24, 0, 1);
        add(7'h5B, 3, 1, 7'h24, 0, 0);
        add(7'h5B, 3, 1, 7'h7F, 0, 0);
        // Edge 41: blink_en falls mid-period; edges 42-50: brightness 3->1 at pwm_cnt=1.
        add(7'h5B, 3, 0, 7'h7F, 0, 1);
        for (int k = 0; k < 4; k++) add(7'h5B, 1, 0, 7'h24, 0, 1);
        for (int k = 0; k < 3; k++) add(7'h5B, 1, 0, 7'h7F, 0, 1);
        add(7'h5B, 1, 0, 7'h24, 0, 1);
        add(7'h5B, 1, 0, 7'h7F, 0, 1);

        reset = 1'b0;
        for (int i = 0; i < n_vec; i++) begin
            drive(vecs[i].seg, vecs[i].br, vecs[i].bl);
            exp_q.push_back({vecs[i].hex, vecs[i].upd, vecs[i].ph});
            @(posedge clk);
            #1;
            e = exp_q.pop_front();
            check_outputs($sformatf("edge%0d", i + 1), e[8:2], e[1], e[0]);
        end

        // Asynchronous reset mid-cycle darkens outputs without a clock edge.
        drive(7'h3F, 2'd3, 1'b0);
        #3;
        reset = 1'b1;
        #1;
        check_outputs("async_reset", 7'h7F, 1'b0, 1'b1);
        @(posedge clk);
        #1;
        check_outputs("held_reset", 7'h7F, 1'b0, 1'b1);
        reset = 1'b0;
        @(posedge clk);
        #1;
        check_outputs("post_reset1", 7'h7F, 1'b1, 1'b1);
        @(posedge clk);
        #1;
        check_outputs("post_reset2", 7'h40, 1'b0, 1'b1);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
